burst_shift_register: RTL and testbench
=======================================

Name: burst_shift_register

Overview:
- Parametrised successor to the team's 4-function shift register.
- Adds rotate and arithmetic-shift modes, a multi-bit shift amount executed one bit per clock, serial-out capture, and a start/busy/done handshake.
- Sits between a control FSM that issues commands and datapath logic that consumes the parallel word or the serial bitstream.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the shift-amount field and internal counter (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  command request; accepted only when busy_o = 0.
- funct_i  input  3  command opcode, type shift_op_t.
- amount_i  input  CNT_W  number of single-bit shifts.
- word_i  input  WIDTH  parallel load data.
- serial_i  input  1  fill bit for SHL/SHR, sampled at every shift edge.
- out_o  output  WIDTH  register contents.
- serial_o  output  1  last bit shifted out.
- busy_o  output  1  high while a shift burst is executing.
- done_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any time, including mid-burst):
  - out_o = 0, serial_o = 0, busy_o = 0, done_o = 0, state = IDLE, counter = 0.
  - No done_o pulse follows a reset.
- Opcodes:
  - NOP = 000, LOAD = 001, SHL = 010, SHR = 011, ROL = 100, ROR = 101, ASR = 110.
  - 111 is reserved and executes as NOP.
- State machine is IDLE / SHIFT; busy_o = (state == SHIFT).
- Accept edge: in IDLE with start_i = 1, the rising edge is the accept edge.
- NOP, reserved opcode, or any shift with amount_i = 0:
  - No register change; stay in IDLE.
  - done_o = 1 for the following cycle.
- LOAD: out_q <= word_i at the accept edge; stay in IDLE; done_o = 1 the following cycle. amount_i is ignored.
- Shift op with amount_i = N > 0:
  - At the accept edge, latch the op and cnt = min(N, WIDTH); values above WIDTH clamp to WIDTH. Go to SHIFT; out_o is unchanged.
  - Each edge in SHIFT performs one single-bit step and decrements cnt.
  - The edge that takes cnt to 0 also returns to IDLE and sets done_o = 1 for exactly one cycle.
  - busy_o is high for exactly N' cycles, where N' is the clamped count. done_o rises on the same edge busy_o falls.
- Single-bit steps; serial_o takes the exiting bit on the same edge:
  - SHL: {q[W-2:0], serial_i}; exits q[W-1].
  - SHR: {serial_i, q[W-1:1]}; exits q[0].
  - ROL: {q[W-2:0], q[W-1]}; exits q[W-1].
  - ROR: {q[0], q[W-1:1]}; exits q[0].
  - ASR: {q[W-1], q[W-1:1]}; exits q[0].
- serial_o holds its value between shifts; LOAD and NOP do not change it.
- Input handling during a burst:
  - start_i while busy is ignored, not queued.
  - funct_i, amount_i and word_i changes during SHIFT have no effect.
  - serial_i is sampled live at each shift edge.
- Back-to-back: start_i asserted in the cycle done_o is high is accepted, since state is IDLE. Issuing commands every cycle in IDLE (LOAD/NOP/zero-amount) yields continuous done_o pulses.

Decomposition:
- Package shift_pkg holds shift_op_t (3-bit enum with the values above) and a function for the clamped count.
- One combinational sub-module, shift_step, maps (op, q, serial_i) to {q_next, bit_out}.
- The top module holds the FSM, counter, out_q and serial_q.

Test Plan (WIDTH = 8):
- Reset, then LOAD with word_i = 0xA5 -> out_o = 0xA5 after one edge; done_o high 1 cycle; busy_o never high.
- From 0xA5: SHL, amount 3, serial_i = 1 -> busy_o 3 cycles; out_o 0x4B, 0x97, 0x2F; serial_o 1, 0, 1; done_o coincides with the busy_o fall.
- From 0x90: ASR, amount 12 -> clamped to 8; busy_o 8 cycles; final out_o = 0xFF, serial_o = 1.
- From 0x3C: ROR, amount 4 -> out_o = 0xC3. ROL amount 1 with start_i pulsed mid-burst is ignored; final value and done_o count (1) unchanged.
- SHR with amount 0, then funct 111 -> each gives done_o next cycle, out_o unchanged, busy_o low.
- Assert rst during cycle 2 of a ROL-5 burst -> immediately out_o = 0, busy_o = 0, serial_o = 0; no done_o afterwards; a new LOAD 0x11 then works normally.

Source files
------------

// File: rtl/burst_shift_register_pkg.sv
// Shared opcode encoding and helpers for the burst shift register and its
// single-bit step logic.
package shift_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LOAD = 3'b001,
      OP_SHL  = 3'b010,
      OP_SHR  = 3'b011,
      OP_ROL  = 3'b100,
      OP_ROR  = 3'b101,
      OP_ASR  = 3'b110,
      OP_RSVD = 3'b111
   } shift_op_t;

   function automatic logic is_shift_op(input shift_op_t op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
             (op == OP_ROR) || (op == OP_ASR);
   endfunction

   // Shifting by more than the register width is pointless, so requests saturate at width.
   function automatic int unsigned clamp_count(input int unsigned amount,
                                               input int unsigned width);
      return (amount > width) ? width : amount;
   endfunction

endpackage

// File: rtl/burst_shift_register_shift_step.sv
// Combinational single-bit step: next register value and the bit that leaves
// the register for each shift/rotate opcode.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] q,
   input  logic             serial_i,
   output logic [WIDTH-1:0] q_next,
   output logic             bit_out
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      q_next  = q;
      bit_out = 1'b0;
      case (shift_op_t'(op))
         OP_SHL: begin
            q_next  = {q[WIDTH-2:0], serial_i};
            bit_out = q[WIDTH-1];
         end
         OP_SHR: begin
            q_next  = {serial_i, q[WIDTH-1:1]};
            bit_out = q[0];
         end
         OP_ROL: begin
            q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
            bit_out = q[WIDTH-1];
         end
         OP_ROR: begin
            q_next  = {q[0], q[WIDTH-1:1]};
            bit_out = q[0];
         end
         OP_ASR: begin
            q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
            bit_out = q[0];
         end
         default: begin
            q_next  = q;
            bit_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/burst_shift_register.sv
// Parametrised shift register executing multi-bit shift/rotate commands one
// bit per clock behind a start/busy/done handshake.
module burst_shift_register
   import shift_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       funct_i,
   input  logic [CNT_W-1:0] amount_i,
   input  logic [WIDTH-1:0] word_i,
   input  logic             serial_i,
   output logic [WIDTH-1:0] out_o,
   output logic             serial_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic STATE_IDLE  = 1'b0;
   localparam logic STATE_SHIFT = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] out_q;
   logic             serial_q;
   logic             done_q;

   shift_op_t        cmd_op;
   logic [CNT_W-1:0] clamped_cnt;
   logic [WIDTH-1:0] step_q;
   logic             step_bit;

   assign cmd_op      = shift_op_t'(funct_i);
   assign clamped_cnt = CNT_W'(clamp_count(32'(amount_i), WIDTH));

   // The step logic always follows the latched opcode so mid-burst funct_i changes are invisible.
   shift_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .op      (op_q),
      .q       (out_q),
      .serial_i(serial_i),
      .q_next  (step_q),
      .bit_out (step_bit)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= STATE_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_NOP;
         out_q    <= '0;
         serial_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            STATE_IDLE: begin
               if (start_i) begin
                  if (cmd_op == OP_LOAD) begin
                     out_q  <= word_i;
                     done_q <= 1'b1;
                  end else if (is_shift_op(cmd_op) && (amount_i != '0)) begin
                     op_q    <= funct_i;
                     cnt_q   <= clamped_cnt;
                     state_q <= STATE_SHIFT;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               out_q    <= step_q;
               serial_q <= step_bit;
               cnt_q    <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= STATE_IDLE;
                  done_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign out_o    = out_q;
   assign serial_o = serial_q;
   assign busy_o   = (state_q == STATE_SHIFT);
   assign done_o   = done_q;

endmodule

// File: tb/tb_burst_shift_register.sv
// Randomised and directed bench for burst_shift_register: a command-level
// model queues the expected result of each command, a monitor checks it at done_o.
module tb_burst_shift_register;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk;
   logic          rst;
   logic          start_i;
   logic [2:0]    funct_i;
   logic [CW-1:0] amount_i;
   logic [W-1:0]  word_i;
   logic          serial_i;
   logic [W-1:0]  out_o;
   logic          serial_o;
   logic          busy_o;
   logic          done_o;

   burst_shift_register #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .funct_i (funct_i),
      .amount_i(amount_i),
      .word_i  (word_i),
      .serial_i(serial_i),
      .out_o   (out_o),
      .serial_o(serial_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic         ser;
      int           busy;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_pass = 0;
   int           done_seen = 0;
   int           done_expected = 0;
   logic [W-1:0] m_q = '0;
   logic         m_ser = 1'b0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Whole-command model: result of an N-bit shift computed in one arithmetic step.
   task automatic model_cmd(input logic [2:0] op, input int amt, input logic [W-1:0] w,
                            input logic s);
      int   n;
      int   x;
      int   sx;
      int   ones;
      exp_t e;
      n    = (amt > W) ? W : amt;
      x    = int'(m_q);
      ones = (1 << n) - 1;
      e.busy = 0;
      case (op)
         3'b001: m_q = w;
         3'b010, 3'b011, 3'b100, 3'b101, 3'b110: begin
            if (n > 0) begin
               e.busy = n;
               case (op)
                  3'b010: begin
                     m_q   = W'((x << n) | (s ? ones : 0));
                     m_ser = 1'((x >> (W - n)) & 1);
                  end
                  3'b011: begin
                     m_q   = W'((x >> n) | (s ? (ones << (W - n)) : 0));
                     m_ser = 1'((x >> (n - 1)) & 1);
                  end
                  3'b100: begin
                     m_q   = W'((x << n) | (x >> (W - n)));
                     m_ser = 1'((x >> (W - n)) & 1);
                  end
                  3'b101: begin
                     m_q   = W'((x >> n) | (x << (W - n)));
                     m_ser = 1'((x >> (n - 1)) & 1);
                  end
                  default: begin
                     sx    = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
                     m_q   = W'(sx >>> n);
                     m_ser = 1'((x >> (n - 1)) & 1);
                  end
               endcase
            end
         end
         default: ;
      endcase
      e.q   = m_q;
      e.ser = m_ser;
      sb.push_back(e);
      done_expected++;
   endtask

   // Called at posedge+1 with busy_o low; returns at posedge+1 after the accept edge.
   task automatic issue(input logic [2:0] op, input int amt, input logic [W-1:0] w,
                        input logic s);
      model_cmd(op, amt, w, s);
      start_i  = 1'b1;
      funct_i  = op;
      amount_i = CW'(amt);
      word_i   = w;
      serial_i = s;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (busy_o && guard < 40) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (busy_o) check("busy_timeout", busy_o, 0);
   endtask

   // Monitor: pops one expectation per done_o pulse and compares the settled outputs.
   initial begin
      int   run = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            run = 0;
         end else begin
            if (busy_o) run++;
            if (done_o) begin
               done_seen++;
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("out_at_done", out_o, e.q);
                  check("serial_at_done", serial_o, e.ser);
                  check("busy_cycles", run, e.busy);
                  check("busy_low_at_done", busy_o, 0);
               end
               run = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] shl_seq [3];
      logic       shl_ser [3];
      shl_seq = '{8'h4B, 8'h97, 8'h2F};
      shl_ser = '{1'b1, 1'b0, 1'b1};

      rst = 1'b1; start_i = 1'b0; funct_i = '0; amount_i = '0; word_i = '0; serial_i = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_out", out_o, 0);
      check("reset_serial", serial_o, 0);
      check("reset_busy", busy_o, 0);
      check("reset_done", done_o, 0);

      issue(3'b001, 0, 8'hA5, 1'b0);
      check("load_value", out_o, 8'hA5);
      check("load_done_pulse", done_o, 1);

      issue(3'b010, 3, 8'h00, 1'b1);
      check("shl_out_unchanged_at_accept", out_o, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         check("shl_busy_during", busy_o, 1);
         @(posedge clk);
         #1;
         check("shl_step_out", out_o, shl_seq[i]);
         check("shl_step_serial", serial_o, shl_ser[i]);
      end
      check("shl_done_on_busy_fall", {busy_o, done_o}, 2'b01);

      issue(3'b001, 0, 8'h90, 1'b0);
      issue(3'b110, 12, 8'h00, 1'b0);
      wait_idle();
      check("asr_clamped_out", out_o, 8'hFF);
      check("asr_serial", serial_o, 1);

      issue(3'b001, 0, 8'h3C, 1'b0);
      issue(3'b101, 4, 8'h00, 1'b0);
      wait_idle();
      check("ror_out", out_o, 8'hC3);

      // A second start during the one-cycle ROL burst must be dropped.
      issue(3'b100, 1, 8'h00, 1'b0);
      start_i = 1'b1; funct_i = 3'b001; word_i = 8'hFF;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rol_ignored_start_out", out_o, 8'h87);
      check("rol_ignored_start_busy", busy_o, 0);

      issue(3'b011, 0, 8'h00, 1'b1);
      issue(3'b111, 5, 8'h55, 1'b1);
      wait_idle();
      check("nop_out_unchanged", out_o, 8'h87);

      for (int i = 0; i < 4; i++) issue(3'b001, 0, 8'(8'h10 + i), 1'b0);

      issue(3'b001, 0, 8'h5A, 1'b0);
      issue(3'b100, 5, 8'h00, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      done_expected -= sb.size();
      sb.delete();
      m_q = '0;
      m_ser = 1'b0;
      #1;
      check("midburst_rst_out", out_o, 0);
      check("midburst_rst_busy", busy_o, 0);
      check("midburst_rst_serial", serial_o, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("no_done_after_rst", done_seen, done_expected);
      issue(3'b001, 0, 8'h11, 1'b0);
      check("load_after_rst", out_o, 8'h11);

      for (int i = 0; i < 60; i++) begin
         issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
               8'($urandom), 1'($urandom));
         wait_idle();
      end

      repeat (3) @(posedge clk);
      #1;
      check("final_out", out_o, m_q);
      check("scoreboard_empty", sb.size(), 0);
      check("done_count", done_seen, done_expected);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
